archon_entropy_hub: RTL and testbench
=====================================

// Module: archon_entropy_hub
// PURPOSE
//  Multi-channel entropy front-end and override arbiter that feeds pipeline_cpu. Health-checks NUM_CH
//  entropy channels, mixes the healthy ones into one word and grades it to an 8-bit level.
//  Runs a 4-state threat FSM and gates lock/flush/release requests through an authentication window.
//  Replaces the hard-wired single-source entropy path and unauthenticated analog overrides.
// PARAMETERS
//  NUM_CH       4   entropy channels (2..8)
//  DATA_W       16  bits per channel; power of 2, 8..128
//  REP_LIMIT    8   identical consecutive valid samples that mark a channel stuck (2..255)
//  AUTH_WINDOW  16  cycles a pending override waits for authentication (1..255)
// PORTS
//  clk                 in   1               system clock, rising edge
//  reset_n             in   1               synchronous active-low reset
//  ch_data             in   NUM_CH*DATA_W   channel samples; channel i at [i*DATA_W +: DATA_W]
//  ch_valid            in   NUM_CH          per-channel sample strobe
//  mission_profile     in   2               0 = relaxed .. 3 = strictest
//  entropy_threshold   in   8               base threshold for the FSM
//  override_req        in   3               one-hot request pulse: [0] lock, [1] flush, [2] release
//  override_auth_valid in   1               authentication token strobe
//  quantum_override    in   1               unauthenticated emergency lock
//  mix_out             out  DATA_W          mixed entropy word
//  mix_valid           out  1               mix_out updated this cycle
//  entropy_level       out  8               graded level of the last mix
//  ch_fault            out  NUM_CH          sticky per-channel stuck flag
//  fsm_state           out  2               0 NORMAL, 1 GUARDED, 2 LOCKDOWN, 3 FAILSAFE
//  lock_out            out  1               level; 1 in LOCKDOWN or FAILSAFE
//  flush_out           out  1               one-cycle flush pulse
//  hazard_out          out  1               fsm_state != NORMAL
//  auth_fail           out  1               one-cycle pulse on override timeout
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all outputs 0, FSM NORMAL, all counters, last-sample regs, mix accumulator
//   and pending override cleared. This applies mid-operation too; FAILSAFE is left only by reset.
//  Health: for each ch_valid[i], if the sample equals last sample, rep_cnt++ (saturating); otherwise rep_cnt=1
//   and last sample is updated. When rep_cnt reaches REP_LIMIT, ch_fault[i] is set and stays set. A sample
//   that trips the fault is excluded from the mix in that same cycle.
//  Mix: contributing set = ch_valid & ~ch_fault. If it is nonempty, acc <= rotl(acc,1) ^ XOR(contributing samples),
//   and next cycle mix_out=acc with mix_valid=1 (1-cycle latency). If it is empty, mix_valid=0 and mix_out holds.
//  Level: computed on each mix update. pc = popcount(new_acc ^ old_acc).
//   entropy_level = min(255, pc << (8 - log2(DATA_W))), clamped at 0 shift for DATA_W >= 256.
//   entropy_level updates in the same cycle as mix_out.
//  Effective threshold: eff_thr = sat0(entropy_threshold - 16*mission_profile). "over" means entropy_level > eff_thr.
//   Over/under streak counters advance only on cycles where mix_valid=1.
//  FSM transitions (priority top to bottom):
//   1. any -> FAILSAFE when popcount(ch_fault) > NUM_CH/2. Sticky until reset.
//   2. NORMAL/GUARDED -> LOCKDOWN on quantum_override (no authentication needed).
//   3. LOCKDOWN -> NORMAL on an authenticated release. Streak counters are cleared.
//   4. NORMAL/GUARDED -> LOCKDOWN on an authenticated lock.
//   5. NORMAL -> GUARDED after 2 consecutive over mixes.
//   6. GUARDED -> LOCKDOWN after 4 consecutive over mixes; flush_out pulses on entry.
//   7. GUARDED -> NORMAL after 4 consecutive non-over mixes.
//   Any state change clears both streak counters.
//  Overrides: a request with the pending slot empty latches req and loads timer=AUTH_WINDOW.
//   Requests arriving while a request is pending are dropped.
//   override_auth_valid in the same cycle as the request, or while pending, authenticates it.
//   The action takes effect in that same cycle and the slot is freed.
//   Otherwise the timer decrements each cycle; at 0 the slot is freed and auth_fail pulses 1 cycle.
//   An authenticated flush pulses flush_out 1 cycle in any state except FAILSAFE.
//   Lock in LOCKDOWN, release outside LOCKDOWN, and any action in FAILSAFE are consumed with no effect.
//   override_auth_valid with no request pending is ignored.
//  Registered outputs: fsm_state, lock_out and hazard_out reflect the new state in the cycle after the transition edge.
// TESTING
//  1. Reset with ch_valid=0 -> all outputs 0 and fsm_state=0; then 4 differing valid samples on ch0 ->
//     mix_valid=1 one cycle after each, ch_fault=0.
//  2. ch1 held at 16'hA5A5 valid for 8 cycles (REP_LIMIT=8) -> ch_fault[1]=1 after the 8th sample; ch1 no longer
//     affects mix_out. Faulting ch0..ch2 -> fsm_state=3 and lock_out=1, persisting until reset_n=0.
//  3. threshold=8'h40, profile=0, sustained level 0xFF -> GUARDED after 2 mixes, LOCKDOWN after 4 more with a
//     1-cycle flush_out; profile=3 with threshold=8'h20 -> eff_thr=0 and any nonzero level counts as over.
//  4. override_req=3'b001, auth 5 cycles later -> LOCKDOWN; req=3'b100 with no auth for 16 cycles ->
//     auth_fail pulse and state stays LOCKDOWN; re-request with same-cycle auth -> NORMAL.
//  5. In GUARDED, quantum_override in the same cycle as an authenticated release -> LOCKDOWN (quantum wins).
//     In FAILSAFE, an authenticated release -> no effect.
//  6. Assert reset_n=0 for 1 cycle while an override is pending and the FSM is in LOCKDOWN -> all outputs 0
//     next cycle; a later lone override_auth_valid -> no action.

Source files
------------

// File: rtl/archon_entropy_hub.sv
// Multi-channel entropy front-end: per-channel stuck detection, rotate-XOR mixer with level grading,
// a four-state threat FSM, and an authentication window for lock/flush/release overrides.
module archon_entropy_hub #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int REP_LIMIT   = 8,
    parameter int AUTH_WINDOW = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [1:0]               mission_profile,
    input  logic [7:0]               entropy_threshold,
    input  logic [2:0]               override_req,
    input  logic                     override_auth_valid,
    input  logic                     quantum_override,
    output logic [DATA_W-1:0]        mix_out,
    output logic                     mix_valid,
    output logic [7:0]               entropy_level,
    output logic [NUM_CH-1:0]        ch_fault,
    output logic [1:0]               fsm_state,
    output logic                     lock_out,
    output logic                     flush_out,
    output logic                     hazard_out,
    output logic                     auth_fail
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_GUARDED  = 2'd1,
        ST_LOCKDOWN = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    localparam int LOG2_W    = $clog2(DATA_W);
    localparam int LVL_SHIFT = (LOG2_W >= 8) ? 0 : (8 - LOG2_W);

    logic [NUM_CH-1:0] r_fault;
    logic [NUM_CH-1:0] w_trip;
    logic [NUM_CH-1:0] w_contrib;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] w_sample;
            logic [DATA_W-1:0] r_last;
            logic [7:0]        r_rep;
            logic [7:0]        w_rep_next;

            assign w_sample   = ch_data[gi*DATA_W +: DATA_W];
            assign w_rep_next = (w_sample != r_last) ? 8'd1 :
                                (r_rep == 8'hFF)     ? 8'hFF : r_rep + 8'd1;
            // The sample that reaches the limit is itself treated as bad.
            assign w_trip[gi] = ch_valid[gi] && (w_rep_next >= 8'(REP_LIMIT));

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_last <= '0;
                    r_rep  <= '0;
                end else if (ch_valid[gi]) begin
                    r_last <= w_sample;
                    r_rep  <= w_rep_next;
                end
            end
        end
    endgenerate

    assign w_contrib = ch_valid & ~r_fault & ~w_trip;

    logic [DATA_W-1:0] r_acc;
    logic              r_mix_valid;
    logic [7:0]        r_level;
    logic [DATA_W-1:0] w_mix_xor;
    logic [DATA_W-1:0] w_acc_next;
    logic [DATA_W-1:0] w_diff;
    logic [15:0]       w_pc;
    logic [15:0]       w_lvl_wide;
    logic [7:0]        w_level_next;

    always_comb begin
        w_mix_xor = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_contrib[i]) begin
                w_mix_xor = w_mix_xor ^ ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_acc_next = {r_acc[DATA_W-2:0], r_acc[DATA_W-1]} ^ w_mix_xor;
    assign w_diff     = w_acc_next ^ r_acc;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_pc = w_pc + 16'(w_diff[i]);
        end
    end

    // Scale the bit-change count so a full-width flip maps to the top of the 8-bit range.
    assign w_lvl_wide   = w_pc << LVL_SHIFT;
    assign w_level_next = (w_lvl_wide > 16'd255) ? 8'hFF : w_lvl_wide[7:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_mix_valid <= 1'b0;
            r_level     <= '0;
            r_fault     <= '0;
        end else begin
            r_fault     <= r_fault | w_trip;
            r_mix_valid <= |w_contrib;
            if (|w_contrib) begin
                r_acc   <= w_acc_next;
                r_level <= w_level_next;
            end
        end
    end

    logic [7:0] w_prof_sub;
    logic [7:0] w_eff_thr;
    logic       w_over_hit;
    logic       w_under_hit;
    logic [2:0] r_over_cnt;
    logic [2:0] r_under_cnt;
    logic [2:0] w_over_inc;
    logic [2:0] w_under_inc;

    assign w_prof_sub  = {2'b00, mission_profile, 4'b0000};
    assign w_eff_thr   = (entropy_threshold > w_prof_sub) ? (entropy_threshold - w_prof_sub) : 8'd0;
    assign w_over_hit  = r_mix_valid && (r_level > w_eff_thr);
    assign w_under_hit = r_mix_valid && !(r_level > w_eff_thr);
    assign w_over_inc  = (r_over_cnt == 3'd7) ? 3'd7 : r_over_cnt + 3'd1;
    assign w_under_inc = (r_under_cnt == 3'd7) ? 3'd7 : r_under_cnt + 3'd1;

    logic       r_pend;
    logic [2:0] r_req;
    logic [7:0] r_timer;
    logic       r_auth_fail;
    logic [2:0] w_req_eff;
    logic       w_auth_hit;
    logic       w_act_lock;
    logic       w_act_flush;
    logic       w_act_release;

    // A pending request owns the slot; anything new arriving meanwhile is dropped.
    assign w_req_eff     = r_pend ? r_req : override_req;
    assign w_auth_hit    = override_auth_valid && (r_pend || (|override_req));
    assign w_act_lock    = w_auth_hit && w_req_eff[0];
    assign w_act_flush   = w_auth_hit && w_req_eff[1];
    assign w_act_release = w_auth_hit && w_req_eff[2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend      <= 1'b0;
            r_req       <= '0;
            r_timer     <= '0;
            r_auth_fail <= 1'b0;
        end else begin
            r_auth_fail <= 1'b0;
            if (w_auth_hit) begin
                r_pend <= 1'b0;
            end else if (!r_pend && (|override_req)) begin
                r_pend  <= 1'b1;
                r_req   <= override_req;
                r_timer <= 8'(AUTH_WINDOW);
            end else if (r_pend) begin
                if (r_timer <= 8'd1) begin
                    r_pend      <= 1'b0;
                    r_auth_fail <= 1'b1;
                end else begin
                    r_timer <= r_timer - 8'd1;
                end
            end
        end
    end

    state_t     r_state;
    state_t     w_state_next;
    logic       w_flush_next;
    logic [3:0] w_fault_cnt;
    logic       r_lock;
    logic       r_hazard;
    logic       r_flush;

    always_comb begin
        w_fault_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_fault_cnt = w_fault_cnt + 4'(r_fault[i]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_flush_next = w_act_flush && (r_state != ST_FAILSAFE);
        if (w_fault_cnt > 4'(NUM_CH / 2)) begin
            w_state_next = ST_FAILSAFE;
        end else begin
            case (r_state)
                ST_NORMAL, ST_GUARDED: begin
                    if (quantum_override || w_act_lock) begin
                        w_state_next = ST_LOCKDOWN;
                    end else if (r_state == ST_NORMAL) begin
                        if (w_over_hit && (w_over_inc >= 3'd2)) begin
                            w_state_next = ST_GUARDED;
                        end
                    end else if (w_over_hit && (w_over_inc >= 3'd4)) begin
                        w_state_next = ST_LOCKDOWN;
                        w_flush_next = 1'b1;
                    end else if (w_under_hit && (w_under_inc >= 3'd4)) begin
                        w_state_next = ST_NORMAL;
                    end
                end
                ST_LOCKDOWN: begin
                    if (w_act_release) begin
                        w_state_next = ST_NORMAL;
                    end
                end
                default: w_state_next = ST_FAILSAFE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_NORMAL;
            r_lock   <= 1'b0;
            r_hazard <= 1'b0;
            r_flush  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_lock   <= (w_state_next == ST_LOCKDOWN) || (w_state_next == ST_FAILSAFE);
            r_hazard <= (w_state_next != ST_NORMAL);
            r_flush  <= w_flush_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || (w_state_next != r_state)) begin
            r_over_cnt  <= '0;
            r_under_cnt <= '0;
        end else if (w_over_hit) begin
            r_over_cnt  <= w_over_inc;
            r_under_cnt <= '0;
        end else if (w_under_hit) begin
            r_under_cnt <= w_under_inc;
            r_over_cnt  <= '0;
        end
    end

    assign mix_out       = r_acc;
    assign mix_valid     = r_mix_valid;
    assign entropy_level = r_level;
    assign ch_fault      = r_fault;
    assign fsm_state     = r_state;
    assign lock_out      = r_lock;
    assign flush_out     = r_flush;
    assign hazard_out    = r_hazard;
    assign auth_fail     = r_auth_fail;

endmodule

// File: tb/tb_archon_entropy_hub.sv
// Bench for archon_entropy_hub: a reference model queues the expected mix/fault outputs per cycle,
// and directed sequences check the FSM, override window and reset behaviour.
module tb_archon_entropy_hub;

    localparam int REP_LIMIT = 8;

    logic        clk;
    logic        reset_n;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [1:0]  mission_profile;
    logic [7:0]  entropy_threshold;
    logic [2:0]  override_req;
    logic        override_auth_valid;
    logic        quantum_override;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic [7:0]  entropy_level;
    logic [3:0]  ch_fault;
    logic [1:0]  fsm_state;
    logic        lock_out;
    logic        flush_out;
    logic        hazard_out;
    logic        auth_fail;

    archon_entropy_hub #(
        .NUM_CH(4), .DATA_W(16), .REP_LIMIT(REP_LIMIT), .AUTH_WINDOW(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .ch_valid(ch_valid),
        .mission_profile(mission_profile), .entropy_threshold(entropy_threshold),
        .override_req(override_req), .override_auth_valid(override_auth_valid),
        .quantum_override(quantum_override), .mix_out(mix_out), .mix_valid(mix_valid),
        .entropy_level(entropy_level), .ch_fault(ch_fault), .fsm_state(fsm_state),
        .lock_out(lock_out), .flush_out(flush_out), .hazard_out(hazard_out),
        .auth_fail(auth_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [15:0] mo;
        logic [7:0]  lvl;
        logic [3:0]  flt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_last[4];
    int          m_rep[4];
    logic [3:0]  m_fault;
    logic [15:0] m_acc;
    logic [7:0]  m_level;
    logic        saw_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the current inputs, queue its prediction, then clock the DUT.
    task automatic step();
        exp_t        e;
        logic [3:0]  trip;
        logic [3:0]  contrib;
        logic [15:0] s;
        logic [15:0] x;
        logic [15:0] nacc;
        int          pc;
        trip = '0;
        x    = '0;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_last[i] = '0;
                m_rep[i]  = 0;
            end
            m_fault = '0;
            m_acc   = '0;
            m_level = '0;
            e.mv    = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ch_valid[i]) begin
                    s = ch_data[i*16 +: 16];
                    if (s == m_last[i]) begin
                        if (m_rep[i] < 255) m_rep[i] = m_rep[i] + 1;
                    end else begin
                        m_rep[i]  = 1;
                        m_last[i] = s;
                    end
                    if (m_rep[i] >= REP_LIMIT) trip[i] = 1'b1;
                end
            end
            contrib = ch_valid & ~m_fault & ~trip;
            for (int i = 0; i < 4; i++) begin
                if (contrib[i]) x = x ^ ch_data[i*16 +: 16];
            end
            if (|contrib) begin
                nacc    = {m_acc[14:0], m_acc[15]} ^ x;
                pc      = $countones(nacc ^ m_acc);
                m_level = (pc * 16 > 255) ? 8'hFF : 8'(pc * 16);
                m_acc   = nacc;
                e.mv    = 1'b1;
            end else begin
                e.mv = 1'b0;
            end
            m_fault = m_fault | trip;
        end
        e.mo  = m_acc;
        e.lvl = m_level;
        e.flt = m_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_mix_valid", 32'(mix_valid), 32'(mon_e.mv));
            chk("sb_mix_out", 32'(mix_out), 32'(mon_e.mo));
            chk("sb_level", 32'(entropy_level), 32'(mon_e.lvl));
            chk("sb_ch_fault", 32'(ch_fault), 32'(mon_e.flt));
        end
    end

    task automatic idle();
        ch_valid            = '0;
        override_req        = '0;
        override_auth_valid = 1'b0;
        quantum_override    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Drive ch0/ch2 so the next mix flips exactly n low bits of the accumulator.
    task automatic drive_pc(input int n);
        logic [16:0] d17;
        logic [15:0] delta;
        logic [15:0] x;
        logic [15:0] r;
        d17      = (17'd1 << n) - 17'd1;
        delta    = d17[15:0];
        r        = 16'($urandom);
        x        = {m_acc[14:0], m_acc[15]} ^ m_acc ^ delta;
        ch_data  = {16'h0000, r ^ x, 16'h0000, r};
        ch_valid = 4'b0101;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mix_out"}, 32'(mix_out), 32'h0);
        chk({tag, "_mix_valid"}, 32'(mix_valid), 32'h0);
        chk({tag, "_level"}, 32'(entropy_level), 32'h0);
        chk({tag, "_ch_fault"}, 32'(ch_fault), 32'h0);
        chk({tag, "_state"}, 32'(fsm_state), 32'h0);
        chk({tag, "_lock"}, 32'(lock_out), 32'h0);
        chk({tag, "_flush"}, 32'(flush_out), 32'h0);
        chk({tag, "_hazard"}, 32'(hazard_out), 32'h0);
        chk({tag, "_auth_fail"}, 32'(auth_fail), 32'h0);
    endtask

    initial begin
        reset_n           = 1'b0;
        ch_data           = '0;
        mission_profile   = 2'd0;
        entropy_threshold = 8'hFF;
        idle();

        // Reset state and basic single-channel mixing.
        do_reset();
        chk_all_zero("t1_reset");
        for (int k = 1; k <= 4; k++) begin
            ch_data  = 64'(k);
            ch_valid = 4'b0001;
            step();
            chk("t1_mix_valid", 32'(mix_valid), 32'h1);
        end
        idle();
        step();
        chk("t1_ch_fault", 32'(ch_fault), 32'h0);

        // Sustained full-scale level: GUARDED then LOCKDOWN with a flush pulse.
        do_reset();
        entropy_threshold = 8'h40;
        mission_profile   = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            drive_pc(16);
            step();
            chk($sformatf("t3_state_%0d", i), 32'(fsm_state),
                (i >= 7) ? 32'd2 : (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("t3_flush_%0d", i), 32'(flush_out), (i == 7) ? 32'd1 : 32'd0);
        end
        idle();

        // Low level is under a 0x20 threshold at profile 0, over it at profile 3.
        do_reset();
        entropy_threshold = 8'h20;
        for (int i = 1; i <= 5; i++) begin
            drive_pc(1);
            step();
        end
        chk("t3b_profile0_state", 32'(fsm_state), 32'd0);
        mission_profile = 2'd3;
        drive_pc(1);
        step();
        chk("t3b_p3_state_1", 32'(fsm_state), 32'd0);
        drive_pc(1);
        step();
        chk("t3b_p3_state_2", 32'(fsm_state), 32'd1);
        idle();
        mission_profile = 2'd0;

        // Override window: delayed-auth lock, timed-out release, same-cycle release, flush.
        do_reset();
        entropy_threshold = 8'hFF;
        override_req = 3'b001;
        step();
        override_req = 3'b000;
        for (int i = 0; i < 4; i++) step();
        chk("t4_pre_auth_state", 32'(fsm_state), 32'd0);
        override_auth_valid = 1'b1;
        step();
        override_auth_valid = 1'b0;
        chk("t4_lock_state", 32'(fsm_state), 32'd2);
        chk("t4_lock_out", 32'(lock_out), 32'd1);
        chk("t4_hazard", 32'(hazard_out), 32'd1);
        override_req = 3'b100;
        step();
        override_req = 3'b000;
        for (int j = 1; j <= 16; j++) begin
            step();
            chk($sformatf("t4_auth_fail_%0d", j), 32'(auth_fail), (j == 16) ? 32'd1 : 32'd0);
        end
        step();
        chk("t4_auth_fail_end", 32'(auth_fail), 32'd0);
        chk("t4_still_lockdown", 32'(fsm_state), 32'd2);
        override_req        = 3'b100;
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t4_release_state", 32'(fsm_state), 32'd0);
        chk("t4_release_lock", 32'(lock_out), 32'd0);
        override_req        = 3'b010;
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t4_flush_pulse", 32'(flush_out), 32'd1);
        step();
        chk("t4_flush_end", 32'(flush_out), 32'd0);

        // Quantum override beats an authenticated release while GUARDED.
        do_reset();
        entropy_threshold = 8'h40;
        for (int i = 0; i < 3; i++) begin
            drive_pc(16);
            step();
        end
        chk("t5_guarded", 32'(fsm_state), 32'd1);
        idle();
        quantum_override    = 1'b1;
        override_req        = 3'b100;
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t5_quantum_state", 32'(fsm_state), 32'd2);
        chk("t5_quantum_noflush", 32'(flush_out), 32'd0);
        step();
        chk("t5_quantum_hold", 32'(fsm_state), 32'd2);

        // Stuck channels: ch1 faults and drops out of the mix; three faults force FAILSAFE.
        do_reset();
        entropy_threshold = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            ch_data  = {32'h0, 16'hA5A5, 16'($urandom)};
            ch_valid = 4'b0011;
            step();
            chk($sformatf("t2_fault_%0d", k), 32'(ch_fault), (k == 8) ? 32'h2 : 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            ch_data  = {32'h0, 16'($urandom), 16'($urandom)};
            ch_valid = 4'b0011;
            step();
        end
        for (int k = 1; k <= 8; k++) begin
            ch_data  = {16'h0, 16'h2222, 16'h0, 16'h1111};
            ch_valid = 4'b0101;
            step();
        end
        chk("t2_three_faults", 32'(ch_fault), 32'h7);
        chk("t2_pre_failsafe", 32'(fsm_state), 32'd0);
        idle();
        step();
        chk("t2_failsafe_state", 32'(fsm_state), 32'd3);
        chk("t2_failsafe_lock", 32'(lock_out), 32'd1);
        chk("t2_failsafe_hazard", 32'(hazard_out), 32'd1);

        // Overrides have no effect in FAILSAFE.
        override_req        = 3'b100;
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t5b_release_ignored", 32'(fsm_state), 32'd3);
        override_req        = 3'b010;
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t5b_flush_ignored", 32'(flush_out), 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("t5b_failsafe_sticky", 32'(fsm_state), 32'd3);

        // Reset mid-operation with a pending override; a lone auth afterwards does nothing.
        do_reset();
        chk("t6_reset_state", 32'(fsm_state), 32'd0);
        override_req        = 3'b001;
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t6_lockdown", 32'(fsm_state), 32'd2);
        override_req = 3'b100;
        step();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk_all_zero("t6_reset");
        step();
        override_auth_valid = 1'b1;
        step();
        idle();
        chk("t6_lone_auth_state", 32'(fsm_state), 32'd0);
        chk("t6_lone_auth_flush", 32'(flush_out), 32'd0);
        saw_fail = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            saw_fail = saw_fail | auth_fail;
        end
        chk("t6_no_timeout", 32'(saw_fail), 32'd0);
        chk("t6_final_state", 32'(fsm_state), 32'd0);

        #10;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
